// File: rtl/leaf_spine_uplink_if.sv
// Endpoint-side flit inputs, uplink flit output and status, grouped for the leaf uplink stage.
interface leaf_spine_uplink_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned NUM_EP = 4
);
  logic [NUM_EP*DWIDTH-1:0] ep_in_data;
  logic [NUM_EP-1:0]        ep_in_valid;
  logic [NUM_EP-1:0]        ep_in_ready;
  logic [DWIDTH-1:0]        up_out_data;
  logic                     up_out_valid;
  logic                     up_full;
  logic [NUM_EP-1:0]        grant;
  logic [15:0]              pkt_sent_cnt;

  modport master (
    output ep_in_data, ep_in_valid, up_full,
    input  ep_in_ready, up_out_data, up_out_valid, grant, pkt_sent_cnt
  );

  modport slave (
    input  ep_in_data, ep_in_valid, up_full,
    output ep_in_ready, up_out_data, up_out_valid, grant, pkt_sent_cnt
  );
endinterface

// File: rtl/leaf_spine_uplink.sv
// Leaf uplink: per-endpoint flit FIFOs, packet-granular round-robin arbiter,
// and a serialiser onto one spine input port that honours the spine full flag.
module leaf_spine_uplink #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NUM_EP     = 4
) (
  input  logic                clk,
  input  logic                reset,
  leaf_spine_uplink_if.slave  bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = $clog2(NUM_EP);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  logic [DWIDTH-1:0] r_mem  [NUM_EP][FIFO_DEPTH];
  logic [PW-1:0]     r_wptr [NUM_EP];
  logic [PW-1:0]     r_rptr [NUM_EP];
  logic [CW-1:0]     r_cnt  [NUM_EP];

  state_t            r_state;
  logic [EW-1:0]     r_rr;
  logic [EW-1:0]     r_owner;
  logic [3:0]        r_rem;
  logic [DWIDTH-1:0] r_data;
  logic              r_valid;
  logic [NUM_EP-1:0] r_grant;
  logic [15:0]       r_pkts;

  logic [NUM_EP-1:0] w_ready;
  logic [NUM_EP-1:0] w_nonempty;
  logic [NUM_EP-1:0] w_push;
  logic [NUM_EP-1:0] w_pop;
  logic [EW-1:0]     w_sel;
  logic              w_sel_ok;
  logic              w_issue;
  logic [DWIDTH-1:0] w_flit;
  logic [3:0]        w_len;

  // Ready depends only on the registered count, so a full FIFO never takes a flit.
  always_comb begin
    for (int i = 0; i < int'(NUM_EP); i++) begin
      w_ready[i]    = (r_cnt[i] != CW'(FIFO_DEPTH));
      w_nonempty[i] = (r_cnt[i] != '0);
      w_push[i]     = bus.ep_in_valid[i] && w_ready[i];
    end
  end

  // Source select: the owner while mid-packet, else first non-empty FIFO from the RR pointer.
  always_comb begin
    w_sel    = r_owner;
    w_sel_ok = 1'b0;
    if (r_state == S_BODY) begin
      w_sel_ok = w_nonempty[r_owner];
    end else begin
      for (int k = int'(NUM_EP) - 1; k >= 0; k--) begin
        if (w_nonempty[r_rr + EW'(k)]) begin
          w_sel    = r_rr + EW'(k);
          w_sel_ok = 1'b1;
        end
      end
    end
    w_issue = !bus.up_full && w_sel_ok;
    w_flit  = r_mem[w_sel][r_rptr[w_sel]];
    w_len   = w_flit[7:4];
    w_pop   = '0;
    if (w_issue) w_pop[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_EP); i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= bus.ep_in_data[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_EP); i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_EP); i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  // Packet FSM with registered uplink outputs; the grant is held for the whole packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_pkts  <= '0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) r_data <= w_flit;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_grant <= NUM_EP'(1) << w_sel;
            r_rr    <= w_sel + EW'(1);
            r_owner <= w_sel;
            r_rem   <= w_len;
            if (w_len != 4'd0) r_state <= S_BODY;
            else               r_pkts  <= r_pkts + 16'd1;
          end else begin
            r_grant <= '0;
          end
        end
        S_BODY: begin
          if (w_issue) begin
            r_rem <= r_rem - 4'd1;
            if (r_rem == 4'd1) begin
              r_state <= S_IDLE;
              r_pkts  <= r_pkts + 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.ep_in_ready  = w_ready;
  assign bus.up_out_data  = r_data;
  assign bus.up_out_valid = r_valid;
  assign bus.grant        = r_grant;
  assign bus.pkt_sent_cnt = r_pkts;

endmodule

// File: tb/tb_leaf_spine_uplink.sv
// Directed bench for leaf_spine_uplink: expected flits/grants queued at stimulus time, checked on issue.
module tb_leaf_spine_uplink;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_spine_uplink_if #(.DWIDTH(16), .NUM_EP(4)) bus ();

  leaf_spine_uplink #(.DWIDTH(16), .FIFO_DEPTH(8), .NUM_EP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  grant;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_pkts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input logic [15:0] d, input logic [3:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] slot(input int ep, input logic [15:0] v);
    logic [63:0] r;
    r = '0;
    r[ep*16 +: 16] = v;
    return r;
  endfunction

  // One clock: drive inputs, step an edge, then score any flit the DUT issued.
  task automatic cyc(input logic [3:0] v, input logic [63:0] d);
    exp_t e;
    bus.ep_in_valid = v;
    bus.ep_in_data  = d;
    @(posedge clk);
    #1;
    bus.ep_in_valid = '0;
    if (bus.up_out_valid === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_flit: observed %0h expected no flit", bus.up_out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("flit_data", 32'(bus.up_out_data), 32'(e.data));
        chk("flit_grant", 32'(bus.grant), 32'(e.grant));
      end
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc(4'h0, 64'h0);
      k++;
    end
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (2) cyc(4'h0, 64'h0);
  endtask

  logic [15:0] bp_f [5];
  logic [15:0] ff_f [8];

  initial begin
    reset = 1'b1;
    bus.ep_in_valid = '0;
    bus.ep_in_data  = '0;
    bus.up_full     = 1'b0;
    exp_pkts = 16'd0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_data",  32'(bus.up_out_data), 32'h0);
    chk("rst_valid", 32'(bus.up_out_valid), 32'h0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_pkts",  32'(bus.pkt_sent_cnt), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ep_in_ready), 32'hF);

    // Round-robin across four zero-length packets, then pointer wrap
    bus.up_full = 1'b1;
    cyc(4'hF, {16'h4003, 16'h3002, 16'h2001, 16'h1000});
    bus.up_full = 1'b0;
    expect_flit(16'h1000, 4'b0001);
    expect_flit(16'h2001, 4'b0010);
    expect_flit(16'h3002, 4'b0100);
    expect_flit(16'h4003, 4'b1000);
    exp_pkts += 16'd4;
    drain(10);
    chk("rr_pkts", 32'(bus.pkt_sent_cnt), 32'(exp_pkts));
    chk("rr_grant_idle", 32'(bus.grant), 32'h0);
    bus.up_full = 1'b1;
    cyc(4'b0101, slot(0, 16'h1100) | slot(2, 16'h3302));
    bus.up_full = 1'b0;
    expect_flit(16'h1100, 4'b0001);
    expect_flit(16'h3302, 4'b0100);
    exp_pkts += 16'd2;
    drain(10);

    // Single packet with latency check
    expect_flit(16'h5123, 4'b0001);
    expect_flit(16'hAAAA, 4'b0001);
    expect_flit(16'hBBBB, 4'b0001);
    cyc(4'b0001, slot(0, 16'h5123));
    chk("lat_t0_valid", 32'(bus.up_out_valid), 32'h0);
    cyc(4'b0001, slot(0, 16'hAAAA));
    chk("lat_t1_valid", 32'(bus.up_out_valid), 32'h1);
    cyc(4'b0001, slot(0, 16'hBBBB));
    chk("single_b1_valid", 32'(bus.up_out_valid), 32'h1);
    cyc(4'h0, 64'h0);
    chk("single_b2_valid", 32'(bus.up_out_valid), 32'h1);
    exp_pkts += 16'd1;
    chk("single_pkts", 32'(bus.pkt_sent_cnt), 32'(exp_pkts));
    drain(5);

    // Wormhole lock with a two-cycle body gap
    expect_flit(16'h6231, 4'b0010);
    expect_flit(16'h1111, 4'b0010);
    expect_flit(16'h2222, 4'b0010);
    expect_flit(16'h3333, 4'b0010);
    expect_flit(16'h7000, 4'b0001);
    cyc(4'b0010, slot(1, 16'h6231));
    cyc(4'b0011, slot(1, 16'h1111) | slot(0, 16'h7000));
    cyc(4'h0, 64'h0);
    cyc(4'h0, 64'h0);
    chk("gap1_valid", 32'(bus.up_out_valid), 32'h0);
    chk("gap1_grant", 32'(bus.grant), 32'b0010);
    cyc(4'b0010, slot(1, 16'h2222));
    chk("gap2_valid", 32'(bus.up_out_valid), 32'h0);
    chk("gap2_grant", 32'(bus.grant), 32'b0010);
    cyc(4'b0010, slot(1, 16'h3333));
    exp_pkts += 16'd2;
    drain(10);
    chk("worm_pkts", 32'(bus.pkt_sent_cnt), 32'(exp_pkts));

    // Backpressure mid-packet
    bp_f = '{16'h8043, 16'hC001, 16'hC002, 16'hC003, 16'hC004};
    bus.up_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_flit(bp_f[i], 4'b1000);
      cyc(4'b1000, slot(3, bp_f[i]));
    end
    bus.up_full = 1'b0;
    cyc(4'h0, 64'h0);
    cyc(4'h0, 64'h0);
    bus.up_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(4'h0, 64'h0);
      chk("bp_valid", 32'(bus.up_out_valid), 32'h0);
    end
    bus.up_full = 1'b0;
    exp_pkts += 16'd1;
    drain(10);
    chk("bp_pkts", 32'(bus.pkt_sent_cnt), 32'(exp_pkts));

    // FIFO full: ninth flit is refused
    ff_f = '{16'h9072, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005, 16'hD006, 16'hD007};
    bus.up_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ff_ready_open", 32'(bus.ep_in_ready[2]), 32'h1);
      expect_flit(ff_f[i], 4'b0100);
      cyc(4'b0100, slot(2, ff_f[i]));
    end
    chk("ff_ready_full", 32'(bus.ep_in_ready[2]), 32'h0);
    cyc(4'b0100, slot(2, 16'hDEAD));
    chk("ff_ready_still_full", 32'(bus.ep_in_ready[2]), 32'h0);
    bus.up_full = 1'b0;
    exp_pkts += 16'd1;
    drain(20);
    chk("ff_pkts", 32'(bus.pkt_sent_cnt), 32'(exp_pkts));
    chk("ff_ready_after", 32'(bus.ep_in_ready[2]), 32'h1);

    // Reset during BODY discards buffered flits
    bus.up_full = 1'b1;
    expect_flit(16'hA050, 4'b0001);
    expect_flit(16'hE001, 4'b0001);
    cyc(4'b0001, slot(0, 16'hA050));
    cyc(4'b0001, slot(0, 16'hE001));
    cyc(4'b0001, slot(0, 16'hE002));
    cyc(4'b0001, slot(0, 16'hE003));
    bus.up_full = 1'b0;
    cyc(4'h0, 64'h0);
    cyc(4'h0, 64'h0);
    bus.up_full = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_data",  32'(bus.up_out_data), 32'h0);
    chk("mid_rst_valid", 32'(bus.up_out_valid), 32'h0);
    chk("mid_rst_grant", 32'(bus.grant), 32'h0);
    chk("mid_rst_pkts",  32'(bus.pkt_sent_cnt), 32'h0);
    cyc(4'h0, 64'h0);
    bus.up_full = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ep_in_ready), 32'hF);
    chk("mid_rst_queue", 32'(sb.size()), 32'h0);
    exp_pkts = 16'd0;
    repeat (4) cyc(4'h0, 64'h0);
    expect_flit(16'hB001, 4'b0010);
    cyc(4'b0010, slot(1, 16'hB001));
    exp_pkts += 16'd1;
    drain(10);
    chk("post_rst_pkts", 32'(bus.pkt_sent_cnt), 32'(exp_pkts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/leaf_spine_uplink.md
Name: leaf_spine_uplink

Overview:
- Leaf-side uplink stage that feeds one leaf port of a spine router, driving its spineNx_in_data/spineNx_in_valid pair.
- Accepts wormhole packets from 4 local endpoints, buffers each endpoint in its own FIFO, and arbitrates round-robin at packet granularity.
- Serialises flits onto the single uplink and honours the spine input FIFO full flag.

Parameters:
- DWIDTH, 16, flit width; header field layout below assumes 16.
- FIFO_DEPTH, 8, entries per endpoint FIFO; power of 2, minimum 2.
- NUM_EP, 4, number of endpoints; fixed at 4 for this revision.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ep_in_data  in  NUM_EP*DWIDTH  endpoint flits; endpoint i occupies bits [i*DWIDTH +: DWIDTH].
- ep_in_valid  in  NUM_EP  flit valid per endpoint.
- ep_in_ready  out  NUM_EP  per-endpoint accept; equals "FIFO i not full".
- up_out_data  out  DWIDTH  flit to spine port (spineNx_in_data).
- up_out_valid  out  1  one-cycle strobe per flit (spineNx_in_valid).
- up_full  in  1  spine port input FIFO full (in_fifo_full).
- grant  out  NUM_EP  one-hot owner of the current packet; 0 when idle.
- pkt_sent_cnt  out  16  packets fully sent, wrapping.

Behaviour:
- Reset (async): all FIFOs empty; state IDLE; RR pointer = 0; up_out_data = 0, up_out_valid = 0, grant = 0, pkt_sent_cnt = 0; ep_in_ready = all 1 once reset deasserts.
- Flit format:
  - Header is the first flit of a packet.
  - [15:12] dest group; [11:10] dest leaf; [9:8] dest node; [7:4] LEN = body flit count (0..15); [3:0] src id.
  - Block only reads LEN; all other bits pass through unmodified.
- Endpoint FIFO i:
  - Push on an edge with ep_in_valid[i] && ep_in_ready[i].
  - ep_in_ready[i] is derived from the registered count only, not from same-cycle pops.
  - A full FIFO never accepts, even when a pop occurs on the same edge.
  - Simultaneous push and pop on a non-full FIFO is allowed; count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Issue condition on each edge: up_full == 0 and the selected FIFO is non-empty. If the condition holds, pop one flit, register it onto up_out_data and set up_out_valid = 1 for that cycle. Otherwise up_out_valid = 0 and up_out_data holds its last value.
- FSM state IDLE:
  - Candidate = first non-empty FIFO searching from RR pointer upward, mod 4.
  - On issue: header emitted; grant = one-hot(candidate); RR pointer = candidate+1 mod 4; remaining = LEN.
  - LEN > 0 -> BODY.
  - LEN == 0 -> stay IDLE; pkt_sent_cnt++; grant returns to 0 next cycle unless another header issues.
- FSM state BODY:
  - Only the granted FIFO is selected; grant is held.
  - On issue: remaining--.
  - Issuing the last body flit (remaining == 1) -> IDLE and pkt_sent_cnt++.
  - Granted FIFO empty mid-packet: stall with no issue, no timeout, grant held; other endpoints wait.
- Back-to-back packets: the next header may issue on the edge immediately after the last body flit (no bubble).
- Latency: a flit pushed at edge t into an empty FIFO with an idle arbiter can issue at edge t+1. up_out_valid is then high during the cycle after t+1.
- up_full asserted in the same cycle as a would-be issue blocks it. The flit stays in the FIFO; nothing is dropped.
- pkt_sent_cnt wraps 0xFFFF -> 0.
- Reset mid-packet discards all buffered flits. The spine-side partial packet is not repaired.

Test Plan:
- Single packet: EP0 sends header 0x5123 (LEN = 2) then 0xAAAA, 0xBBBB, up_full = 0 -> up_out shows 0x5123, 0xAAAA, 0xBBBB on 3 consecutive cycles; first flit one edge after push; grant = 0001; pkt_sent_cnt = 1.
- Round-robin: EP0..EP3 each preload one header with LEN = 0 -> issue order EP0, EP1, EP2, EP3; then EP0 and EP2 reload -> EP0 before EP2 (pointer wrapped to 0).
- Wormhole lock: EP1 packet with LEN = 3 starts; EP0 header arrives mid-packet -> all 3 EP1 body flits issue before the EP0 header; EP1 body gap of 2 cycles -> up_out_valid low for 2 cycles, grant stays 0010.
- Backpressure: up_full = 1 for 5 cycles mid-packet -> no up_out_valid in those cycles; flits resume in order afterwards with no loss or duplication.
- FIFO full: hold up_full = 1 and push 9 flits into EP2 -> ep_in_ready[2] = 0 after 8 pushes and the 9th is not accepted; release -> exactly 8 flits out.
- Reset mid-packet: assert reset during BODY -> outputs 0, grant = 0, ep_in_ready = all 1, pkt_sent_cnt = 0; new traffic after reset issues normally.
